// File: rtl/mc_residual_sequencer.sv
// Inter MC residual sequencer: loads block rows, emits residual rows,
// then per-component chroma DC coefficients, for one macroblock.
module mc_residual_sequencer #(
  parameter int BLK_ROWS  = 4,
  parameter int LUMA_BLKS = 16,
  parameter int N_DC_MAX  = 8,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    chroma_mode,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic          dst_ready,
  output logic          dst_valid,
  output logic          load_curr,
  output logic          load_ref,
  output logic          output_residual_row,
  output logic          output_dcco,
  output logic [CW-1:0] row_idx,
  output logic [CW-1:0] blk_idx,
  output logic [1:0]    plane,
  output logic [CW-1:0] dc_idx,
  output logic          mb_busy,
  output logic          mb_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EMIT, S_DC, S_DONE
  } state_t;

  localparam int N420 = (N_DC_MAX < 4) ? N_DC_MAX : 4;
  localparam int N422 = (N_DC_MAX < 8) ? N_DC_MAX : 8;
  localparam logic [CW-1:0] ROW_LAST  = CW'(BLK_ROWS - 1);
  localparam logic [CW-1:0] LUMA_LAST = CW'(LUMA_BLKS - 1);
  localparam logic [CW-1:0] N420_LAST = CW'(N420 - 1);
  localparam logic [CW-1:0] N422_LAST = CW'(N422 - 1);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic [1:0]    r_plane, w_plane_nxt;
  logic [CW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_blk, w_blk_nxt;
  logic [CW-1:0] r_dc, w_dc_nxt;

  logic          w_src_rdy;
  logic          w_dst_vld;
  logic          w_src_xfer;
  logic          w_dst_xfer;
  logic [CW-1:0] w_ncb_last;
  logic [CW-1:0] w_blk_last;

  // src_ready is gated by reset so it drops asynchronously with it
  assign w_src_rdy  = reset &&
                      ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_dst_vld  = (r_state == S_EMIT) || (r_state == S_DC);
  assign w_src_xfer = src_valid && w_src_rdy;
  assign w_dst_xfer = w_dst_vld && dst_ready;
  assign w_ncb_last = (r_mode == 2'd2) ? N422_LAST : N420_LAST;
  assign w_blk_last = (r_plane == 2'd0) ? LUMA_LAST : w_ncb_last;

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_plane_nxt = r_plane;
    w_row_nxt   = r_row;
    w_blk_nxt   = r_blk;
    w_dc_nxt    = r_dc;
    unique case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_src_xfer) begin
          if (r_state == S_IDLE)
            w_mode_nxt = (chroma_mode == 2'd3) ? 2'd0 : chroma_mode;
          if (r_row == ROW_LAST) begin
            w_row_nxt   = '0;
            w_state_nxt = S_EMIT;
          end else begin
            w_row_nxt   = r_row + 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_EMIT: begin
        if (w_dst_xfer) begin
          if (r_row != ROW_LAST) begin
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_row_nxt = '0;
            if (r_blk != w_blk_last) begin
              w_blk_nxt   = r_blk + 1'b1;
              w_state_nxt = S_LOAD;
            end else if (r_plane == 2'd0 && r_mode == 2'd0) begin
              w_state_nxt = S_DONE;
            end else if (r_plane == 2'd0) begin
              w_plane_nxt = 2'd1;
              w_blk_nxt   = '0;
              w_state_nxt = S_LOAD;
            end else begin
              w_state_nxt = S_DC;
            end
          end
        end
      end
      S_DC: begin
        if (w_dst_xfer) begin
          if (r_dc != w_ncb_last) begin
            w_dc_nxt = r_dc + 1'b1;
          end else begin
            w_dc_nxt = '0;
            if (r_plane == 2'd1) begin
              w_plane_nxt = 2'd2;
              w_blk_nxt   = '0;
              w_state_nxt = S_LOAD;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        w_plane_nxt = 2'd0;
        w_blk_nxt   = '0;
        w_dc_nxt    = '0;
        w_row_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= 2'd0;
      r_plane <= 2'd0;
      r_row   <= '0;
      r_blk   <= '0;
      r_dc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_plane <= w_plane_nxt;
      r_row   <= w_row_nxt;
      r_blk   <= w_blk_nxt;
      r_dc    <= w_dc_nxt;
    end
  end

  assign src_ready           = w_src_rdy;
  assign dst_valid           = w_dst_vld;
  assign load_curr           = w_src_xfer;
  assign load_ref            = w_src_xfer;
  assign output_residual_row = (r_state == S_EMIT) && dst_ready;
  assign output_dcco         = (r_state == S_DC) && dst_ready;
  assign row_idx             = r_row;
  assign blk_idx             = r_blk;
  assign plane               = r_plane;
  assign dc_idx              = r_dc;
  assign mb_busy             = (r_state == S_LOAD) ||
                               (r_state == S_EMIT) ||
                               (r_state == S_DC);
  assign mb_done             = (r_state == S_DONE);

endmodule

// File: tb/tb_mc_residual_sequencer.sv
// Scoreboard bench for mc_residual_sequencer: a per-macroblock model
// queues expected loads/rows/DCs; a monitor pops them on every transfer.
module tb_mc_residual_sequencer;

  localparam int BR  = 4;
  localparam int LB  = 16;
  localparam int NDC = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    chroma_mode = 2'd0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic          dst_ready = 1'b0;
  logic          dst_valid;
  logic          load_curr;
  logic          load_ref;
  logic          output_residual_row;
  logic          output_dcco;
  logic [CW-1:0] row_idx;
  logic [CW-1:0] blk_idx;
  logic [1:0]    plane;
  logic [CW-1:0] dc_idx;
  logic          mb_busy;
  logic          mb_done;

  mc_residual_sequencer #(
    .BLK_ROWS(BR), .LUMA_BLKS(LB), .N_DC_MAX(NDC), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .chroma_mode(chroma_mode),
    .src_valid(src_valid), .src_ready(src_ready),
    .dst_ready(dst_ready), .dst_valid(dst_valid),
    .load_curr(load_curr), .load_ref(load_ref),
    .output_residual_row(output_residual_row),
    .output_dcco(output_dcco),
    .row_idx(row_idx), .blk_idx(blk_idx), .plane(plane),
    .dc_idx(dc_idx), .mb_busy(mb_busy), .mb_done(mb_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int src_q[$];
  int dst_q[$];
  int rows_seen = 0;
  int dc_seen   = 0;
  int done_seen = 0;
  bit done_flag = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int enc(input int k, input int p,
                             input int b, input int i);
    return (k << 24) | (p << 16) | (b << 8) | i;
  endfunction

  function automatic int ncb_of(input int m);
    if (m == 1) return (NDC < 4) ? NDC : 4;
    if (m == 2) return (NDC < 8) ? NDC : 8;
    return 0;
  endfunction

  // Expected traffic for one macroblock in chroma mode m
  task automatic model_mb(input int m, output int erows, output int edc);
    int mm;
    int ncb;
    int np;
    int nb;
    mm  = (m == 3) ? 0 : m;
    ncb = ncb_of(mm);
    np  = (mm == 0) ? 1 : 3;
    for (int p = 0; p < np; p++) begin
      nb = (p == 0) ? LB : ncb;
      for (int b = 0; b < nb; b++) begin
        for (int r = 0; r < BR; r++) src_q.push_back(enc(0, p, b, r));
        for (int r = 0; r < BR; r++) dst_q.push_back(enc(1, p, b, r));
      end
      if (p > 0)
        for (int d = 0; d < ncb; d++) dst_q.push_back(enc(2, p, 0, d));
    end
    erows = BR * (LB + 2 * ncb);
    edc   = 2 * ncb;
  endtask

  task automatic pop_cmp(input string name, input int got, input bit is_src);
    int e;
    if (is_src ? (src_q.size() == 0) : (dst_q.size() == 0)) begin
      check({name, "_unexpected"}, got, -1);
    end else begin
      e = is_src ? src_q.pop_front() : dst_q.pop_front();
      check(name, got, e);
    end
  endtask

  initial begin : monitor
    bit prev_valid;
    bit prev_xfer;
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
      end else begin
        if (prev_valid && !prev_xfer)
          check("dst_valid_hold", int'(dst_valid), 1);
        check("xfer_flag", int'(output_residual_row | output_dcco),
              int'(dst_valid & dst_ready));
        check("load_curr_hs", int'(load_curr), int'(src_valid & src_ready));
        check("load_ref_hs", int'(load_ref), int'(src_valid & src_ready));
        if (dst_valid)
          check("busy_when_valid", int'(mb_busy), 1);
        if (load_curr)
          pop_cmp("load_seq",
                  enc(0, int'(plane), int'(blk_idx), int'(row_idx)), 1'b1);
        if (output_residual_row) begin
          rows_seen++;
          pop_cmp("row_seq",
                  enc(1, int'(plane), int'(blk_idx), int'(row_idx)), 1'b0);
        end
        if (output_dcco) begin
          dc_seen++;
          pop_cmp("dc_seq", enc(2, int'(plane), 0, int'(dc_idx)), 1'b0);
        end
        if (mb_done) begin
          done_seen++;
          done_flag = 1'b1;
          check("done_after_xfer", int'(prev_xfer), 1);
          check("done_queues_empty", src_q.size() + dst_q.size(), 0);
          check("done_src_ready", int'(src_ready), 0);
          check("done_busy", int'(mb_busy), 0);
        end
        prev_valid = dst_valid;
        prev_xfer  = dst_valid && dst_ready;
      end
    end
  end

  task automatic run_mb(input int m, input int m2, input bit stall);
    int er;
    int ed;
    int r0;
    int d0;
    int dn0;
    bit toggled;
    chroma_mode = 2'(m);
    model_mb(m, er, ed);
    r0 = rows_seen;
    d0 = dc_seen;
    dn0 = done_seen;
    done_flag = 1'b0;
    toggled = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (done_flag) break;
      if (m2 >= 0 && mb_busy && !toggled) begin
        chroma_mode = 2'(m2);
        toggled = 1'b1;
      end
      src_valid = stall ? (($urandom % 4) != 0) : 1'b1;
      dst_ready = stall ? (($urandom % 3) != 0) : 1'b1;
    end
    src_valid = 1'b0;
    dst_ready = 1'b0;
    check("mb_completed", int'(done_flag), 1);
    check("row_count", rows_seen - r0, er);
    check("dc_count", dc_seen - d0, ed);
    check("done_pulses", done_seen - dn0, 1);
    @(negedge clk);
    check("idle_src_ready", int'(src_ready), 1);
    check("idle_plane", int'(plane), 0);
    check("idle_blk", int'(blk_idx), 0);
    check("idle_dc", int'(dc_idx), 0);
    src_q.delete();
    dst_q.delete();
  endtask

  task automatic run_abort();
    int er;
    int ed;
    int dn0;
    bit hit;
    chroma_mode = 2'd1;
    model_mb(1, er, ed);
    dn0 = done_seen;
    hit = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (plane == 2'd1 && blk_idx == 4'd2) begin
        hit = 1'b1;
        break;
      end
      src_valid = (($urandom % 4) != 0);
      dst_ready = (($urandom % 3) != 0);
    end
    check("abort_point_reached", int'(hit), 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_flags",
          int'({src_ready, dst_valid, load_curr, load_ref,
                output_residual_row, output_dcco, mb_busy, mb_done}), 0);
    check("abort_plane", int'(plane), 0);
    check("abort_row", int'(row_idx), 0);
    check("abort_blk", int'(blk_idx), 0);
    check("abort_dc", int'(dc_idx), 0);
    src_q.delete();
    dst_q.delete();
    src_valid = 1'b0;
    dst_ready = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    check("post_abort_src_ready", int'(src_ready), 1);
    check("post_abort_busy", int'(mb_busy), 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_seen - dn0, 0);
  endtask

  initial begin
    #12;
    check("rst_flags",
          int'({src_ready, dst_valid, load_curr, load_ref,
                output_residual_row, output_dcco, mb_busy, mb_done}), 0);
    check("rst_idx", int'({plane, row_idx, blk_idx, dc_idx}), 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_src_ready", int'(src_ready), 1);
    check("rst_release_busy", int'(mb_busy), 0);

    run_mb(0, -1, 1'b0);
    run_mb(1, -1, 1'b0);
    run_mb(2, -1, 1'b0);
    run_mb(3, -1, 1'b0);
    run_mb(1, -1, 1'b1);
    run_mb(2, -1, 1'b1);
    run_mb(0, -1, 1'b1);
    run_mb(1, 2, 1'b1);
    run_mb(2, -1, 1'b1);
    run_abort();
    run_mb(1, -1, 1'b1);
    for (int k = 0; k < 4; k++)
      run_mb(int'($urandom_range(0, 3)), -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_residual_sequencer.md
Name: mc_residual_sequencer

Overview:
Parametrised successor to the motion-compensation residual controller. Sequences one macroblock through the inter MC path. Each 4x4-style block is loaded row by row from the current/reference fetch stage, and its residual rows are then emitted downstream. After each chroma component's blocks, the block emits that component's DC coefficients to the chroma DC transform. Unlike the previous generation, it adds the following:
- Runtime chroma format: 4:0:0, 4:2:0 or 4:2:2.
- Parametrised block geometry.
- Internal row, block and DC counters.
- A strict AXI-style valid/ready handshake on both sides.
- Macroblock start/done status.

Parameters:
BLK_ROWS, 4, rows per block. Must be 2 or more.
LUMA_BLKS, 16, luma blocks per macroblock.
N_DC_MAX, 8, maximum chroma blocks (equal to DC coefficients) per chroma component.
CW, 4, counter width. Must satisfy 2^CW >= max(BLK_ROWS, LUMA_BLKS, N_DC_MAX).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
chroma_mode  input  2  0: 4:0:0, 1: 4:2:0 (4 blocks per component), 2: 4:2:2 (8 blocks per component), 3: reserved, treated as 4:0:0. Sampled on the first src transfer of a macroblock.
src_valid  input  1  upstream row available.
src_ready  output  1  ready to accept a row.
dst_ready  input  1  downstream accepts a residual row or DC coefficient.
dst_valid  output  1  residual row or DC coefficient valid.
load_curr  output  1  capture the current row; equals src_valid && src_ready.
load_ref  output  1  capture the reference row; equals src_valid && src_ready.
output_residual_row  output  1  residual row transferred this cycle.
output_dcco  output  1  DC coefficient transferred this cycle.
row_idx  output  CW  row within the current block, for load and emit.
blk_idx  output  CW  block index within the current plane.
plane  output  2  0 = Y, 1 = Cb, 2 = Cr.
dc_idx  output  CW  DC coefficient index during the DC phase.
mb_busy  output  1  high from the first src transfer until mb_done.
mb_done  output  1  one-cycle pulse after the final transfer of a macroblock.

Behaviour:
- Reset (async assert, sync deassert):
  - State is IDLE and all counters are 0.
  - chroma_mode register is 0.
  - Outputs src_ready, dst_valid, load_*, output_*, mb_busy, mb_done, plane, row_idx, blk_idx and dc_idx are all 0.
- Transfer definitions:
  - A src transfer is src_valid && src_ready.
  - A dst transfer is dst_valid && dst_ready.
  - dst_valid never depends combinationally on dst_ready. Once raised, it holds until the transfer completes.
- States:
  - IDLE: src_ready=1. The first src transfer latches chroma_mode, sets mb_busy, counts row 0, and moves to LOAD (or to EMIT if BLK_ROWS would wrap).
  - LOAD: src_ready=1. Each src transfer increments row_idx. A transfer at row_idx = BLK_ROWS-1 clears row_idx and moves to EMIT.
  - EMIT: src_ready=0, dst_valid=1, output_residual_row = dst transfer. Each transfer increments row_idx. On the transfer at row BLK_ROWS-1, row_idx clears and the next state is chosen as follows:
    - If the plane has more blocks: blk_idx+1, go to LOAD.
    - Else if plane = Y and mode is 4:0:0: go to DONE.
    - Else if plane = Y: plane becomes 1, blk_idx clears, go to LOAD.
    - Else (chroma plane): go to DC.
  - DC: dst_valid=1, output_dcco = dst transfer. Each transfer increments dc_idx. On the transfer at dc_idx = NCB-1, dc_idx clears and the next state is chosen:
    - If plane = 1: plane becomes 2, blk_idx clears, go to LOAD.
    - Else: go to DONE.
  - DONE: a single cycle. mb_done=1, mb_busy drops, then the block returns to IDLE with plane, blk_idx and dc_idx all 0.
- Block counts:
  - NCB = 4 for 4:2:0 and 8 for 4:2:2, capped at N_DC_MAX.
  - Luma wraps at LUMA_BLKS-1.
- No overlap: a new macroblock cannot start in the DONE cycle because src_ready=0 there.
- Latency: the first residual row is valid one cycle after the final load transfer of its block.
- Backpressure: dst_ready low holds state, counters and dst_valid indefinitely. load_* are never asserted outside src transfers.
- chroma_mode changes mid-macroblock are ignored until the next IDLE.
- Asynchronous reset mid-macroblock aborts immediately. No mb_done is issued.

Test Plan:
- 4:0:0 with src_valid and dst_ready held at 1 → 16 x (4 loads + 4 emits) = 128 transfers. mb_done rises exactly once, on the cycle after the 64th output_residual_row. No output_dcco.
- 4:2:0 → 64 luma rows, then plane 1: 16 rows followed by 4 DC coefficients (dc_idx 0..3), then the same for plane 2. Total 96 output_residual_row and 8 output_dcco.
- 4:2:2 → 32 chroma rows per component, 8 DC coefficients per component, dc_idx reaches 7. Total 128 output_residual_row and 16 output_dcco.
- Random dst_ready stall pattern (e.g. 1 of every 3 cycles low) → dst_valid never drops before a transfer, and no row or DC coefficient is lost or duplicated. Counts match the corresponding non-stalled case.
- chroma_mode toggled from 1 to 2 during luma → the macroblock still completes as 4:2:0. The next macroblock runs as 4:2:2.
- reset driven to 0 during plane 1, block 2 → all outputs go to 0 asynchronously. After release, the block is in IDLE with src_ready=1 and mb_busy=0.
